// File: rtl/hps_pixel_writer_if.sv
// HPS register-write port and image-memory pixel-write port of the pixel writer.
interface hps_pixel_writer_if #(
    parameter int ADDR_W = 16
);
    logic [7:0]        hps_writedata;
    logic              hps_write;
    logic              hps_chipselect;
    logic [3:0]        hps_address;
    logic              img_mem_ready;
    logic              img_mem_we;
    logic [ADDR_W-1:0] img_mem_addr;
    logic [3:0]        img_mem_data;

    // Environment side: HPS bridge plus image memory.
    modport master (
        output hps_writedata, hps_write, hps_chipselect, hps_address, img_mem_ready,
        input  img_mem_we, img_mem_addr, img_mem_data
    );

    // Pixel writer side.
    modport slave (
        input  hps_writedata, hps_write, hps_chipselect, hps_address, img_mem_ready,
        output img_mem_we, img_mem_addr, img_mem_data
    );
endinterface

// File: rtl/hps_pixel_writer.sv
// Buffers HPS byte writes in a FIFO and drains each byte as two 4-bit pixel
// writes (low nibble, then high nibble) to consecutive image-memory addresses.
module hps_pixel_writer #(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    hps_pixel_writer_if.slave             bus,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 8 + ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [15:0]       ptr_ext;
    logic              ovf_q;
    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_idx_q, rd_idx_q;
    logic [AW:0]       count_q, count_d;
    logic [7:0]        hold_byte_q, hold_byte_d;
    logic [ADDR_W-1:0] hold_base_q, hold_base_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        data_q, data_d;
    logic [EW-1:0]     head;

    logic wr, wr_lo, wr_hi, wr_data, wr_ctrl;
    logic full, empty, push, pop, drop, flush, ovf_clr;

    assign wr      = bus.hps_write & bus.hps_chipselect;
    assign wr_lo   = wr && (bus.hps_address == 4'd0);
    assign wr_hi   = wr && (bus.hps_address == 4'd1);
    assign wr_data = wr && (bus.hps_address == 4'd2);
    assign wr_ctrl = wr && (bus.hps_address == 4'd3);

    // Fullness uses the registered count, so a full-cycle write drops even if a pop happens too.
    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign push    = wr_data && !full;
    assign drop    = wr_data && full;
    assign flush   = wr_ctrl && bus.hps_writedata[1];
    assign ovf_clr = wr_ctrl && bus.hps_writedata[0];
    assign head    = mem_q[rd_idx_q];

    assign busy             = !empty || (state_q != S_IDLE);
    assign overflow         = ovf_q;
    assign fifo_level       = count_q;
    assign bus.img_mem_we   = we_q;
    assign bus.img_mem_addr = addr_q;
    assign bus.img_mem_data = data_q;

    // Write pointer: byte loads via ADDR_LO/ADDR_HI, advance by two pixels per accepted DATA byte.
    always_comb begin
        ptr_ext = 16'(ptr_q);
        ptr_d   = ptr_q;
        if (wr_lo) begin
            ptr_ext[7:0] = bus.hps_writedata;
            ptr_d        = ptr_ext[ADDR_W-1:0];
        end else if (wr_hi) begin
            ptr_ext[15:8] = bus.hps_writedata;
            ptr_d         = ptr_ext[ADDR_W-1:0];
        end else if (push) begin
            ptr_d = ptr_q + ADDR_W'(2);
        end
    end

    // FIFO occupancy next value.
    always_comb begin
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer, overflow flag and FIFO index/count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= '0;
            ovf_q    <= 1'b0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
            if (flush) begin
                wr_idx_q <= '0;
                rd_idx_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_idx_q <= wr_idx_q + AW'(1);
                if (pop)  rd_idx_q <= rd_idx_q + AW'(1);
                count_q <= count_d;
            end
        end
    end

    // FIFO storage; emptiness is tracked by the indices, so entries need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_idx_q] <= {bus.hps_writedata, ptr_q};
        end
    end

    // Drain FSM state and hold registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hold_byte_q <= '0;
            hold_base_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_byte_q <= hold_byte_d;
            hold_base_q <= hold_base_d;
        end
    end

    // Drain FSM next state; a pop loads the head entry into the hold registers.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        hold_byte_d = hold_byte_q;
        hold_base_d = hold_base_q;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    hold_byte_d = head[EW-1 -: 8];
                    hold_base_d = head[ADDR_W-1:0];
                    state_d     = S_LO;
                end
            end
            S_LO: begin
                if (bus.img_mem_ready) state_d = S_HI;
            end
            S_HI: begin
                if (bus.img_mem_ready) begin
                    if (!empty) begin
                        pop         = 1'b1;
                        hold_byte_d = head[EW-1 -: 8];
                        hold_base_d = head[ADDR_W-1:0];
                        state_d     = S_LO;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d     = S_IDLE;
            pop         = 1'b0;
            hold_byte_d = hold_byte_q;
            hold_base_d = hold_base_q;
        end
    end

    // Pixel outputs decoded from the next state so they are registered; IDLE keeps the last pixel.
    always_comb begin
        we_d   = (state_d != S_IDLE);
        addr_d = addr_q;
        data_d = data_q;
        unique case (state_d)
            S_LO: begin
                addr_d = hold_base_d;
                data_d = hold_byte_d[3:0];
            end
            S_HI: begin
                addr_d = hold_base_d + 1'b1;
                data_d = hold_byte_d[7:4];
            end
            default: ;
        endcase
    end

    // Pixel output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end
endmodule

// File: tb/tb_hps_pixel_writer.sv
// Directed bench for hps_pixel_writer with a transaction-level pixel model.
module tb_hps_pixel_writer;
    localparam int ADDR_W     = 16;
    localparam int FIFO_DEPTH = 8;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  data;
    } pix_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy, overflow;
    logic [3:0] fifo_level;

    int unsigned checks  = 0;
    int unsigned errors  = 0;
    bit          started = 1'b0;

    logic [15:0] m_ptr;
    bit          m_ovf;
    pix_t        exp_q[$];

    hps_pixel_writer_if #(.ADDR_W(ADDR_W)) bus ();

    hps_pixel_writer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ptr = '0;
        m_ovf = 1'b0;
        exp_q.delete();
    endtask

    // One register write; the model is updated at the sampling edge.
    task automatic reg_write(input logic [3:0] a, input logic [7:0] d, input bit drop);
        pix_t p;
        bus.hps_address    = a;
        bus.hps_writedata  = d;
        bus.hps_write      = 1'b1;
        bus.hps_chipselect = 1'b1;
        @(posedge clk);
        case (a)
            4'd0: m_ptr[7:0]  = d;
            4'd1: m_ptr[15:8] = d;
            4'd2: begin
                if (drop) begin
                    m_ovf = 1'b1;
                end else begin
                    p.addr = m_ptr;          p.data = d[3:0]; exp_q.push_back(p);
                    p.addr = m_ptr + 16'd1;  p.data = d[7:4]; exp_q.push_back(p);
                    m_ptr  = m_ptr + 16'd2;
                end
            end
            4'd3: begin
                if (d[0]) m_ovf = 1'b0;
                if (d[1]) exp_q.delete();
            end
            default: ;
        endcase
        #1;
        bus.hps_write      = 1'b0;
        bus.hps_chipselect = 1'b0;
    endtask

    // Every accepted pixel write must be the next expected one; overflow tracks the model.
    always @(negedge clk) begin
        pix_t p;
        if (started && !reset) begin
            chk("overflow", overflow, m_ovf);
            if (bus.img_mem_we && bus.img_mem_ready) begin
                chk("pixel_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    p = exp_q.pop_front();
                    chk("pix_addr", bus.img_mem_addr, p.addr);
                    chk("pix_data", bus.img_mem_data, p.data);
                end
            end
        end
    end

    initial begin
        bus.hps_address    = '0;
        bus.hps_writedata  = '0;
        bus.hps_write      = 1'b0;
        bus.hps_chipselect = 1'b0;
        bus.img_mem_ready  = 1'b1;
        reset              = 1'b1;
        model_reset();
        tick();
        tick();
        reset   = 1'b0;
        started = 1'b1;
        chk("rst_we",    bus.img_mem_we, 0);
        chk("rst_addr",  bus.img_mem_addr, 0);
        chk("rst_data",  bus.img_mem_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy",  busy, 0);

        // Single byte, latency and IDLE hold.
        reg_write(4'd0, 8'h10, 0);
        reg_write(4'd1, 8'h00, 0);
        reg_write(4'd2, 8'hA5, 0);
        chk("t2_level_n1", fifo_level, 1);
        chk("t2_we_n1", bus.img_mem_we, 0);
        tick();
        chk("t2_we_lo", bus.img_mem_we, 1);
        chk("t2_addr_lo", bus.img_mem_addr, 16'h0010);
        chk("t2_data_lo", bus.img_mem_data, 4'h5);
        tick();
        chk("t2_we_hi", bus.img_mem_we, 1);
        chk("t2_addr_hi", bus.img_mem_addr, 16'h0011);
        chk("t2_data_hi", bus.img_mem_data, 4'hA);
        tick();
        chk("t2_we_idle", bus.img_mem_we, 0);
        chk("t2_addr_idle", bus.img_mem_addr, 16'h0011);
        chk("t2_busy_idle", busy, 0);
        reg_write(4'd2, 8'h01, 0);
        tick();
        chk("t2_next_addr", bus.img_mem_addr, 16'h0012);
        repeat (3) tick();

        // Backpressure in LO.
        bus.img_mem_ready = 1'b0;
        reg_write(4'd0, 8'h10, 0);
        reg_write(4'd1, 8'h00, 0);
        reg_write(4'd2, 8'hA5, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_we_held", bus.img_mem_we, 1);
            chk("t3_addr_held", bus.img_mem_addr, 16'h0010);
            chk("t3_data_held", bus.img_mem_data, 4'h5);
            tick();
        end
        bus.img_mem_ready = 1'b1;
        repeat (4) tick();

        // Overflow: one byte stalled in LO, then ten writes into the FIFO.
        bus.img_mem_ready = 1'b0;
        reg_write(4'd0, 8'h00, 0);
        reg_write(4'd1, 8'h01, 0);
        reg_write(4'd2, 8'hB0, 0);
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            reg_write(4'd2, 8'(8'h11 * (i + 1)), i >= 8);
        end
        chk("t4_level_full", fifo_level, 8);
        chk("t4_ovf_set", overflow, 1);
        reg_write(4'd3, 8'h01, 0);
        chk("t4_ovf_clr", overflow, 0);
        bus.img_mem_ready = 1'b1;
        repeat (25) tick();
        chk("t4_busy_drained", busy, 0);
        reg_write(4'd2, 8'h99, 0);
        tick();
        chk("t4_ptr_adv16", bus.img_mem_addr, 16'h0112);
        repeat (3) tick();

        // Address wrap, ignored registers and chip-select gating.
        reg_write(4'd0, 8'hFF, 0);
        reg_write(4'd1, 8'hFF, 0);
        reg_write(4'd2, 8'h3C, 0);
        tick();
        chk("t5_addr_ffff", bus.img_mem_addr, 16'hFFFF);
        chk("t5_data_c", bus.img_mem_data, 4'hC);
        tick();
        chk("t5_addr_0000", bus.img_mem_addr, 16'h0000);
        chk("t5_data_3", bus.img_mem_data, 4'h3);
        reg_write(4'd7, 8'h12, 0);
        bus.hps_address    = 4'd2;
        bus.hps_writedata  = 8'hEE;
        bus.hps_write      = 1'b1;
        bus.hps_chipselect = 1'b0;
        tick();
        bus.hps_write = 1'b0;
        chk("t5_cs_gated", fifo_level, 0);
        reg_write(4'd2, 8'h77, 0);
        tick();
        chk("t5_ptr_0001", bus.img_mem_addr, 16'h0001);
        repeat (3) tick();

        // Flush while stalled in LO.
        bus.img_mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) reg_write(4'd2, 8'(8'hC0 + i), 0);
        tick();
        chk("t6_level_pre", fifo_level, 3);
        chk("t6_we_pre", bus.img_mem_we, 1);
        reg_write(4'd3, 8'h02, 0);
        chk("t6_we_flush", bus.img_mem_we, 0);
        chk("t6_level_flush", fifo_level, 0);
        chk("t6_busy_flush", busy, 0);
        bus.img_mem_ready = 1'b1;
        repeat (10) tick();

        // Reset in the middle of a drain with overflow set.
        bus.img_mem_ready = 1'b0;
        for (int i = 0; i < 10; i++) reg_write(4'd2, 8'(8'h21 + i), i == 9);
        chk("t1_ovf_pre", overflow, 1);
        bus.img_mem_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        chk("t1_we", bus.img_mem_we, 0);
        chk("t1_level", fifo_level, 0);
        chk("t1_ovf", overflow, 0);
        chk("t1_busy", busy, 0);
        reg_write(4'd2, 8'h5A, 0);
        tick();
        chk("t1_ptr0_addr", bus.img_mem_addr, 16'h0000);
        chk("t1_ptr0_data", bus.img_mem_data, 4'hA);
        tick();
        chk("t1_ptr1_addr", bus.img_mem_addr, 16'h0001);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        chk("pending_at_end", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
